// File: rtl/rvx_spi_target.sv
// -----------------------------------------------------------------------------
// rvx_spi_target
//   SPI target (slave), mode 0 (CPOL=0, CPHA=0), MSB first. It answers the rvx
//   SPI controller. All SPI pins are brought into the local clock domain
//   through SYNC_STAGES-deep synchronisers. Edges are detected on the
//   synchronised copies. The local side sees two decoupled queues:
//     - an RX valid/ready output holding the last received word
//     - a 1-deep TX holding register written with tx_valid/tx_ready
//
// Ports
//   clock        in   system clock
//   reset_n      in   asynchronous active-low reset
//   sclk         in   SPI clock from the controller (idles low)
//   mosi         in   SPI data from the controller
//   cs           in   chip select, active-low
//   miso         out  SPI data to the controller (registered)
//   rx_data      out  last received word
//   rx_valid     out  rx_data holds an unconsumed word
//   rx_ready     in   consumer accepts rx_data when rx_valid && rx_ready
//   tx_data      in   next word to transmit
//   tx_valid     in   tx_data presented
//   tx_ready     out  holding register empty; write on tx_valid && tx_ready
//   rx_overrun   out  1-cycle pulse: a completed word was dropped
//   tx_underrun  out  1-cycle pulse: a word started with an empty holding reg
//   busy         out  1 while the synchronised cs is low
// -----------------------------------------------------------------------------
module rvx_spi_target #(
    parameter int unsigned           DATA_WIDTH  = 8,
    parameter int unsigned           SYNC_STAGES = 2,
    parameter logic [DATA_WIDTH-1:0] IDLE_WORD   = {DATA_WIDTH{1'b1}}
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  sclk,
    input  logic                  mosi,
    input  logic                  cs,
    output logic                  miso,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    input  logic                  rx_ready,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    output logic                  rx_overrun,
    output logic                  tx_underrun,
    output logic                  busy
);

    localparam int unsigned      CNT_W    = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } state_e;

    // ------------------------------------------------------------------
    // Synchronisers and edge-detect history
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] sclk_sync_q;
    logic [SYNC_STAGES-1:0] mosi_sync_q;
    logic [SYNC_STAGES-1:0] cs_sync_q;
    logic                   sclk_prev_q;
    logic                   cs_prev_q;

    logic sclk_s;
    logic mosi_s;
    logic cs_s;

    // Pin synchronisers; cs resets high (deselected) so reset never looks like a cs fall.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sclk_sync_q <= {SYNC_STAGES{1'b0}};
            mosi_sync_q <= {SYNC_STAGES{1'b0}};
            cs_sync_q   <= {SYNC_STAGES{1'b1}};
            sclk_prev_q <= 1'b0;
            cs_prev_q   <= 1'b1;
        end else begin
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi};
            cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], cs};
            sclk_prev_q <= sclk_sync_q[SYNC_STAGES-1];
            cs_prev_q   <= cs_sync_q[SYNC_STAGES-1];
        end
    end

    assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
    assign mosi_s = mosi_sync_q[SYNC_STAGES-1];
    assign cs_s   = cs_sync_q[SYNC_STAGES-1];

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_e                state_q;
    state_e                state_d;
    logic [CNT_W-1:0]      bit_cnt_q;
    logic [DATA_WIDTH-1:0] rx_shift_q;
    logic [DATA_WIDTH-1:0] tx_shift_q;
    logic [DATA_WIDTH-1:0] tx_shift_d;
    logic [DATA_WIDTH-1:0] tx_hold_q;
    logic                  start_pend_q;  // a word completed; next sclk fall starts a new one
    logic                  under_pend_q;  // IDLE_WORD loaded on a fall; report once clocked
    logic                  miso_q;
    logic [DATA_WIDTH-1:0] rx_data_q;
    logic                  rx_valid_q;
    logic                  tx_ready_q;
    logic                  rx_overrun_q;
    logic                  tx_underrun_q;
    logic                  busy_q;

    // ------------------------------------------------------------------
    // Event decode (each fires for exactly one cycle)
    // ------------------------------------------------------------------
    logic                  sclk_rise_s;
    logic                  sclk_fall_s;
    logic                  cs_fall_s;
    logic                  cs_rise_s;
    logic                  active_s;
    logic                  abort_s;
    logic                  bit_rise_s;
    logic                  word_done_s;
    logic                  cs_start_s;
    logic                  fall_start_s;
    logic                  word_start_s;
    logic                  tx_write_s;
    logic                  rx_accept_s;
    logic [DATA_WIDTH-1:0] rx_word_s;

    assign sclk_rise_s  = sclk_s & ~sclk_prev_q;
    assign sclk_fall_s  = ~sclk_s & sclk_prev_q;
    assign cs_fall_s    = cs_prev_q & ~cs_s;
    assign cs_rise_s    = ~cs_prev_q & cs_s;
    assign active_s     = (state_q == ST_ACTIVE);
    // A cs rise wins over any sclk edge seen in the same cycle.
    assign abort_s      = active_s & cs_rise_s;
    assign bit_rise_s   = active_s & ~cs_rise_s & sclk_rise_s;
    assign word_done_s  = bit_rise_s & (bit_cnt_q == LAST_BIT);
    assign cs_start_s   = (state_q == ST_IDLE) & cs_fall_s;
    assign fall_start_s = active_s & ~cs_rise_s & sclk_fall_s & start_pend_q;
    assign word_start_s = cs_start_s | fall_start_s;
    assign tx_write_s   = tx_valid & tx_ready_q;
    assign rx_accept_s  = ~rx_valid_q | rx_ready;
    assign rx_word_s    = {rx_shift_q[DATA_WIDTH-2:0], mosi_s};

    // Next FSM state and next TX shifter contents (miso is registered from the latter).
    always_comb begin
        state_d    = state_q;
        tx_shift_d = tx_shift_q;
        case (state_q)
            ST_IDLE: begin
                if (cs_fall_s) begin
                    state_d = ST_ACTIVE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACTIVE: begin
                if (cs_rise_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_ACTIVE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (abort_s) begin
            tx_shift_d = {DATA_WIDTH{1'b0}};
        end else if (word_start_s) begin
            // Holding register full -> send it; empty -> send the idle pattern.
            if (tx_ready_q) begin
                tx_shift_d = IDLE_WORD;
            end else begin
                tx_shift_d = tx_hold_q;
            end
        end else if (active_s && sclk_fall_s) begin
            tx_shift_d = {tx_shift_q[DATA_WIDTH-2:0], 1'b0};
        end else begin
            tx_shift_d = tx_shift_q;
        end
    end

    // Transfer FSM, shifters, RX/TX queues and registered outputs.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ST_IDLE;
            bit_cnt_q     <= {CNT_W{1'b0}};
            rx_shift_q    <= {DATA_WIDTH{1'b0}};
            tx_shift_q    <= {DATA_WIDTH{1'b0}};
            tx_hold_q     <= {DATA_WIDTH{1'b0}};
            start_pend_q  <= 1'b0;
            under_pend_q  <= 1'b0;
            miso_q        <= 1'b0;
            rx_data_q     <= {DATA_WIDTH{1'b0}};
            rx_valid_q    <= 1'b0;
            tx_ready_q    <= 1'b1;
            rx_overrun_q  <= 1'b0;
            tx_underrun_q <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            tx_shift_q    <= tx_shift_d;
            miso_q        <= (state_d == ST_ACTIVE) ? tx_shift_d[DATA_WIDTH-1] : 1'b0;
            busy_q        <= (state_d == ST_ACTIVE);
            rx_overrun_q  <= 1'b0;
            tx_underrun_q <= 1'b0;

            // Bit counter and receive shifter; a cs rise throws away a partial word.
            if (abort_s) begin
                bit_cnt_q    <= {CNT_W{1'b0}};
                rx_shift_q   <= {DATA_WIDTH{1'b0}};
                start_pend_q <= 1'b0;
            end else if (bit_rise_s) begin
                rx_shift_q <= rx_word_s;
                if (word_done_s) begin
                    bit_cnt_q    <= {CNT_W{1'b0}};
                    start_pend_q <= 1'b1;
                end else begin
                    bit_cnt_q <= bit_cnt_q + CNT_ONE;
                end
            end else if (word_start_s) begin
                start_pend_q <= 1'b0;
            end

            // RX queue: a word completing while the previous one is still held is dropped.
            if (word_done_s) begin
                if (rx_accept_s) begin
                    rx_data_q  <= rx_word_s;
                    rx_valid_q <= 1'b1;
                end else begin
                    rx_overrun_q <= 1'b1;
                end
            end else if (rx_valid_q && rx_ready) begin
                rx_valid_q <= 1'b0;
            end

            // Underrun: reported at once for a cs-fall start. The sclk fall that follows the
            // last bit of a transfer is also a word start; its underrun is held back until the
            // controller actually clocks that word, so a plain single-word transfer stays quiet.
            if (abort_s) begin
                under_pend_q <= 1'b0;
            end else if (cs_start_s) begin
                tx_underrun_q <= tx_ready_q;
                under_pend_q  <= 1'b0;
            end else if (fall_start_s) begin
                under_pend_q <= tx_ready_q;
            end else if (bit_rise_s && under_pend_q) begin
                tx_underrun_q <= 1'b1;
                under_pend_q  <= 1'b0;
            end

            // Holding register: a load empties it, a write fills it. Both never coincide on a
            // full register, so a same-cycle write lands in the register the load just saw empty.
            if (word_start_s && !tx_ready_q) begin
                tx_ready_q <= 1'b1;
            end
            if (tx_write_s) begin
                tx_hold_q  <= tx_data;
                tx_ready_q <= 1'b0;
            end
        end
    end

    assign miso        = miso_q;
    assign rx_data     = rx_data_q;
    assign rx_valid    = rx_valid_q;
    assign tx_ready    = tx_ready_q;
    assign rx_overrun  = rx_overrun_q;
    assign tx_underrun = tx_underrun_q;
    assign busy        = busy_q;

endmodule
